// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - parametrised APB slave register file with wait states, error response and optional byte strobes (APB_PSTRB_EN)
module apb_slave_regfile #(
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  ADDR_WIDTH  = 32,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AL = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [IW-1:0]         idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic [ADDR_WIDTH-1:0] word_d;
  logic [IW-1:0]         idx_d;
  logic                  misaligned_d;
  logic                  oor_d;
  logic                  ro_d;
  logic                  err_d;
  logic [NB-1:0]         strb_d;
  logic [DATA_WIDTH-1:0] rd_setup_d;
  logic [DATA_WIDTH-1:0] rd_wait_d;

  // Decode the setup-phase address and classify the access as legal or erroneous
  always_comb begin
    word_d       = paddr >> AL;
    idx_d        = word_d[IW-1:0];
    misaligned_d = |(paddr & ADDR_WIDTH'(NB - 1));
    oor_d        = word_d >= ADDR_WIDTH'(NUM_REGS);
    ro_d         = !oor_d && pwrite && RO_MASK[idx_d];
    err_d        = misaligned_d || oor_d || ro_d;
`ifdef APB_PSTRB_EN
    strb_d       = pstrb;
`else
    strb_d       = '1;
`endif
    // Writes and errors return zero read data; only legal reads expose a register
    rd_setup_d   = (err_d || pwrite) ? '0 : regs_q[idx_d];
    rd_wait_d    = (err_q || write_q) ? '0 : regs_q[idx_q];
  end

  // Transfer FSM, registered outputs and register storage
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      // Completion outputs are single-cycle pulses; zero unless entering DONE
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      case (state_q)
        S_IDLE: begin
          // Only a genuine setup cycle starts a transfer; a stray penable is ignored
          if (psel && !penable) begin
            idx_q   <= idx_d;
            write_q <= pwrite;
            err_q   <= err_d;
            wdata_q <= pwdata;
            strb_q  <= strb_d;
            if (WAIT_STATES == 0) begin
              state_q   <= S_DONE;
              pready_q  <= 1'b1;
              pslverr_q <= err_d;
              prdata_q  <= rd_setup_d;
            end else begin
              cnt_q   <= 4'(WAIT_STATES);
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!psel) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q   <= S_DONE;
              pready_q  <= 1'b1;
              pslverr_q <= err_q;
              prdata_q  <= rd_wait_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          // A deselect during the completion cycle discards the write
          if (psel && write_q && !err_q) begin
            for (int b = 0; b < NB; b++) begin
              if (strb_q[b]) regs_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule
